// File: rtl/instruction_queue_decoder.sv
// Ingress FIFO for host instruction words with legality filtering and a registered
// decode stage that feeds control_unit.
package tpu_package;
  localparam int MUL_SIZE = 8;

  typedef struct packed {
    logic [2:0]  MAC_op;
    logic [7:0]  V_dim;
    logic [7:0]  U_dim;
    logic [7:0]  ITER_dim;
    logic [11:0] ub_addr_start_rd;
    logic [11:0] ub_addr_start_wr;
    logic [6:0]  V_dim1;
    logic [6:0]  U_dim1;
    logic [6:0]  ITER_dim1;
  } decoded_instr_t;
endpackage

module instruction_queue_decoder #(
  parameter int DEPTH    = 8,
  parameter int INSTR_W  = 64,
  parameter int MAX_OP   = 4,
  parameter int MUL_SIZE = tpu_package::MUL_SIZE
) (
  input  logic                            clk_i,
  input  logic                            rstN_i,
  input  logic [INSTR_W-1:0]              host_instr_i,
  input  logic                            host_valid_i,
  output logic                            host_ready_o,
  input  logic                            flush_i,
  input  logic                            read_instruction_i,
  output tpu_package::decoded_instr_t     decoded_instruction_o,
  output logic                            iq_empty_o,
  output logic [$clog2(DEPTH+2)-1:0]      level_o,
  output logic                            err_illegal_o,
  input  logic                            err_clr_i
);
  import tpu_package::*;

  localparam int RAW_W = 51;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int LW    = $clog2(DEPTH + 2);
  localparam int SH    = $clog2(MUL_SIZE);

  logic [RAW_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic             r_headValid;
  logic             r_err;
  logic             r_live;
  decoded_instr_t   r_head;

  logic [RAW_W-1:0] w_word;
  logic [2:0]       w_op;
  logic [7:0]       w_vDim;
  logic [7:0]       w_uDim;
  logic [7:0]       w_iterDim;
  logic             w_legal;
  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_push;
  logic             w_reject;
  logic             w_pop;
  logic             w_load;
  logic [PW-1:0]    w_count;
  logic             w_unusedHi;

  // Tile count minus one: ceil(dim/MUL_SIZE)-1, kept in 9 bits until the final truncation.
  function automatic logic [6:0] tileM1(input logic [7:0] dim);
    return 7'(((({1'b0, dim} + 9'(MUL_SIZE - 1)) >> SH) - 9'd1));
  endfunction

  function automatic decoded_instr_t decode(input logic [RAW_W-1:0] raw);
    decoded_instr_t d;
    d.MAC_op           = raw[50:48];
    d.V_dim            = raw[47:40];
    d.U_dim            = raw[39:32];
    d.ITER_dim         = raw[31:24];
    d.ub_addr_start_rd = raw[23:12];
    d.ub_addr_start_wr = raw[11:0];
    d.V_dim1           = tileM1(raw[47:40]);
    d.U_dim1           = tileM1(raw[39:32]);
    d.ITER_dim1        = tileM1(raw[31:24]);
    return d;
  endfunction

  assign w_word     = host_instr_i[RAW_W-1:0];
  assign w_unusedHi = ^host_instr_i[INSTR_W-1:RAW_W];
  assign w_op       = w_word[50:48];
  assign w_vDim     = w_word[47:40];
  assign w_uDim     = w_word[39:32];
  assign w_iterDim  = w_word[31:24];
  assign w_legal    = (int'(w_op) <= MAX_OP) && (w_vDim != 8'd0) &&
                      (w_uDim != 8'd0) && (w_iterDim != 8'd0);

  assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_count = r_wrPtr - r_rdPtr;

  // Rejected words still complete the handshake; only legal ones are stored.
  assign host_ready_o = r_live && !w_full && !flush_i;
  assign w_accept     = host_valid_i && host_ready_o;
  assign w_push       = w_accept && w_legal;
  assign w_reject     = w_accept && !w_legal;
  assign w_pop        = read_instruction_i && r_headValid;
  assign w_load       = (!r_headValid || w_pop) && !w_empty;

  assign decoded_instruction_o = r_head;
  assign iq_empty_o            = !r_headValid;
  assign level_o               = LW'(w_count) + LW'(r_headValid);
  assign err_illegal_o         = r_err;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wrPtr[AW-1:0]] <= w_word;
    end
  end

  // Flush wins over push and pop but leaves the error flag and stale head data alone.
  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_headValid <= 1'b0;
      r_head      <= '0;
      r_err       <= 1'b0;
      r_live      <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_reject) begin
        r_err <= 1'b1;
      end else if (err_clr_i) begin
        r_err <= 1'b0;
      end
      if (flush_i) begin
        r_wrPtr     <= '0;
        r_rdPtr     <= '0;
        r_headValid <= 1'b0;
      end else begin
        if (w_push) begin
          r_wrPtr <= r_wrPtr + PW'(1);
        end
        if (w_load) begin
          r_rdPtr     <= r_rdPtr + PW'(1);
          r_head      <= decode(r_mem[r_rdPtr[AW-1:0]]);
          r_headValid <= 1'b1;
        end else if (w_pop) begin
          r_headValid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_instruction_queue_decoder.sv
// Self-checking bench for instruction_queue_decoder: decode table plus scoreboard-modelled
// sequences for fill, rejection, streaming, flush and asynchronous reset.
module tb_instruction_queue_decoder;
  import tpu_package::*;

  localparam int DEPTH = 8;
  localparam int MUL   = 8;

  logic           clk_i = 1'b0;
  logic           rstN_i;
  logic [63:0]    host_instr_i;
  logic           host_valid_i;
  logic           host_ready_o;
  logic           flush_i;
  logic           read_instruction_i;
  decoded_instr_t decoded_instruction_o;
  logic           iq_empty_o;
  logic [3:0]     level_o;
  logic           err_illegal_o;
  logic           err_clr_i;

  int total = 0;
  int bad   = 0;

  // Scoreboard: decoded words expected in FIFO order, plus the expected head register.
  decoded_instr_t mFifo[$];
  decoded_instr_t mHead;
  bit             mHeadValid;
  bit             mErr;
  bit             mLive;

  typedef struct {
    logic [63:0] word;
    bit          legal;
    logic [6:0]  v1;
    logic [6:0]  u1;
    logic [6:0]  i1;
  } vec_t;

  vec_t tbl[10];

  always #5 clk_i = ~clk_i;

  instruction_queue_decoder #(
    .DEPTH(DEPTH), .INSTR_W(64), .MAX_OP(4), .MUL_SIZE(MUL)
  ) dut (
    .clk_i                 (clk_i),
    .rstN_i                (rstN_i),
    .host_instr_i          (host_instr_i),
    .host_valid_i          (host_valid_i),
    .host_ready_o          (host_ready_o),
    .flush_i               (flush_i),
    .read_instruction_i    (read_instruction_i),
    .decoded_instruction_o (decoded_instruction_o),
    .iq_empty_o            (iq_empty_o),
    .level_o               (level_o),
    .err_illegal_o         (err_illegal_o),
    .err_clr_i             (err_clr_i)
  );

  function automatic logic [63:0] mk(input logic [2:0] op, input logic [7:0] v,
                                     input logic [7:0] u, input logic [7:0] it,
                                     input logic [11:0] rd, input logic [11:0] wr,
                                     input logic [12:0] hi);
    return {hi, op, v, u, it, rd, wr};
  endfunction

  function automatic bit refLegal(input logic [63:0] w);
    return (w[50:48] <= 3'd4) && (w[47:40] != 0) && (w[39:32] != 0) && (w[31:24] != 0);
  endfunction

  function automatic decoded_instr_t refDecode(input logic [63:0] w);
    decoded_instr_t d;
    d.MAC_op           = w[50:48];
    d.V_dim            = w[47:40];
    d.U_dim            = w[39:32];
    d.ITER_dim         = w[31:24];
    d.ub_addr_start_rd = w[23:12];
    d.ub_addr_start_wr = w[11:0];
    d.V_dim1           = 7'((int'(w[47:40]) + MUL - 1) / MUL - 1);
    d.U_dim1           = 7'((int'(w[39:32]) + MUL - 1) / MUL - 1);
    d.ITER_dim1        = 7'((int'(w[31:24]) + MUL - 1) / MUL - 1);
    return d;
  endfunction

  task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive at the negedge, check ready before the edge, advance the model,
  // check state 1ns after the edge, return at the next negedge.
  task automatic applyStimulus(input bit v, input logic [63:0] w, input bit rd,
                               input bit fl, input bit clr);
    bit ready;
    bit acc;
    bit pop;
    host_valid_i       = v;
    host_instr_i       = w;
    read_instruction_i = rd;
    flush_i            = fl;
    err_clr_i          = clr;
    #1;
    ready = mLive && (mFifo.size() < DEPTH) && !fl;
    checkOutput("host_ready", 80'(host_ready_o), 80'(ready));
    acc = v && ready;
    @(posedge clk_i);
    mLive = 1'b1;
    if (acc && !refLegal(w)) mErr = 1'b1;
    else if (clr) mErr = 1'b0;
    if (fl) begin
      mFifo.delete();
      mHeadValid = 1'b0;
    end else begin
      pop = rd && mHeadValid;
      if ((!mHeadValid || pop) && mFifo.size() > 0) begin
        mHead      = mFifo.pop_front();
        mHeadValid = 1'b1;
      end else if (pop) begin
        mHeadValid = 1'b0;
      end
      if (acc && refLegal(w)) mFifo.push_back(refDecode(w));
    end
    #1;
    checkOutput("iq_empty", 80'(iq_empty_o), 80'(!mHeadValid));
    checkOutput("level", 80'(level_o), 80'(mFifo.size() + int'(mHeadValid)));
    checkOutput("err_illegal", 80'(err_illegal_o), 80'(mErr));
    checkOutput("decoded", 80'(decoded_instruction_o), 80'(mHead));
    @(negedge clk_i);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"}, 80'(host_ready_o), 80'(0));
    checkOutput({tag, "_empty"}, 80'(iq_empty_o), 80'(1));
    checkOutput({tag, "_level"}, 80'(level_o), 80'(0));
    checkOutput({tag, "_err"}, 80'(err_illegal_o), 80'(0));
    checkOutput({tag, "_decoded"}, 80'(decoded_instruction_o), 80'(0));
  endtask

  task automatic resetModel();
    mFifo.delete();
    mHead      = '0;
    mHeadValid = 1'b0;
    mErr       = 1'b0;
    mLive      = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 3; i++) applyStimulus(0, 64'd0, 1, 0, 0);
  endtask

  initial begin
    tbl[0] = '{word: mk(1, 16, 8, 32, 12'h100, 12'h200, 13'h0),     legal: 1, v1: 7'd1,  u1: 7'd0,  i1: 7'd3};
    tbl[1] = '{word: mk(0, 1, 255, 9, 12'hABC, 12'h123, 13'h1FFF),  legal: 1, v1: 7'd0,  u1: 7'd31, i1: 7'd1};
    tbl[2] = '{word: mk(4, 64, 65, 128, 12'hFFF, 12'h000, 13'h0AA), legal: 1, v1: 7'd7,  u1: 7'd8,  i1: 7'd15};
    tbl[3] = '{word: mk(5, 16, 16, 16, 12'h0, 12'h0, 13'h0),        legal: 0, v1: 7'd0,  u1: 7'd0,  i1: 7'd0};
    tbl[4] = '{word: mk(2, 0, 16, 16, 12'h1, 12'h2, 13'h0),         legal: 0, v1: 7'd0,  u1: 7'd0,  i1: 7'd0};
    tbl[5] = '{word: mk(3, 200, 0, 4, 12'h3, 12'h4, 13'h0),         legal: 0, v1: 7'd0,  u1: 7'd0,  i1: 7'd0};
    tbl[6] = '{word: mk(7, 255, 7, 1, 12'h5, 12'h6, 13'h0),         legal: 0, v1: 7'd0,  u1: 7'd0,  i1: 7'd0};
    tbl[7] = '{word: mk(2, 255, 7, 1, 12'h001, 12'h002, 13'h1555),  legal: 1, v1: 7'd31, u1: 7'd0,  i1: 7'd0};
    tbl[8] = '{word: mk(3, 5, 9, 17, 12'h7, 12'h8, 13'h0),          legal: 1, v1: 7'd0,  u1: 7'd1,  i1: 7'd2};
    tbl[9] = '{word: mk(1, 1, 1, 0, 12'h9, 12'hA, 13'h0),           legal: 0, v1: 7'd0,  u1: 7'd0,  i1: 7'd0};

    resetModel();
    rstN_i = 1'b0;
    host_valid_i = 0; host_instr_i = '0; read_instruction_i = 0; flush_i = 0; err_clr_i = 0;
    repeat (3) @(negedge clk_i);
    checkResetState("reset");
    rstN_i = 1'b1;

    // First word after reset: two cycles to become visible.
    applyStimulus(0, 64'd0, 0, 0, 0);
    applyStimulus(1, tbl[0].word, 0, 0, 0);
    checkOutput("latency_still_empty", 80'(iq_empty_o), 80'(1));
    applyStimulus(0, 64'd0, 0, 0, 0);
    checkOutput("latency_visible", 80'(iq_empty_o), 80'(0));
    checkOutput("tp1_V1", 80'(decoded_instruction_o.V_dim1), 80'(1));
    checkOutput("tp1_U1", 80'(decoded_instruction_o.U_dim1), 80'(0));
    checkOutput("tp1_I1", 80'(decoded_instruction_o.ITER_dim1), 80'(3));
    checkOutput("tp1_level", 80'(level_o), 80'(1));
    applyStimulus(0, 64'd0, 1, 0, 0);

    // Decode table.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 64'd0, 0, 0, 1);
      applyStimulus(1, tbl[i].word, 0, 0, 0);
      applyStimulus(0, 64'd0, 0, 0, 0);
      if (tbl[i].legal) begin
        checkOutput($sformatf("tbl%0d_empty", i), 80'(iq_empty_o), 80'(0));
        checkOutput($sformatf("tbl%0d_V1", i), 80'(decoded_instruction_o.V_dim1), 80'(tbl[i].v1));
        checkOutput($sformatf("tbl%0d_U1", i), 80'(decoded_instruction_o.U_dim1), 80'(tbl[i].u1));
        checkOutput($sformatf("tbl%0d_I1", i), 80'(decoded_instruction_o.ITER_dim1), 80'(tbl[i].i1));
        checkOutput($sformatf("tbl%0d_raw", i), 80'(decoded_instruction_o.ub_addr_start_rd),
                    80'(tbl[i].word[23:12]));
        applyStimulus(0, 64'd0, 1, 0, 0);
      end else begin
        checkOutput($sformatf("tbl%0d_err", i), 80'(err_illegal_o), 80'(1));
        checkOutput($sformatf("tbl%0d_level", i), 80'(level_o), 80'(0));
      end
    end

    // Clear and a new rejection in the same cycle: flag stays set; then a plain clear.
    applyStimulus(1, tbl[3].word, 0, 0, 1);
    checkOutput("clr_and_reject", 80'(err_illegal_o), 80'(1));
    applyStimulus(0, 64'd0, 0, 0, 1);
    checkOutput("clr_alone", 80'(err_illegal_o), 80'(0));

    // Fill to DEPTH+1 without popping, then one pop reopens the queue a cycle later.
    for (int i = 0; i < 12; i++)
      applyStimulus(1, mk(3'(i % 5), 8'(i + 1), 8'(2 * i + 3), 8'(255 - i), 12'(i), 12'(i * 3), 13'h0), 0, 0, 0);
    checkOutput("fill_level", 80'(level_o), 80'(9));
    checkOutput("fill_ready_low", 80'(host_ready_o), 80'(0));
    applyStimulus(1, mk(1, 9, 9, 9, 12'h11, 12'h22, 13'h0), 1, 0, 0);
    applyStimulus(1, mk(2, 10, 10, 10, 12'h33, 12'h44, 13'h0), 0, 0, 0);
    checkOutput("refill_level", 80'(level_o), 80'(9));
    drain();

    // Streaming: three preloaded, then push+pop every cycle across several wraps.
    for (int i = 0; i < 3; i++)
      applyStimulus(1, mk(3'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3), 12'(i), 12'(i), 13'h0), 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1, mk(3'($urandom_range(0, 4)), 8'($urandom_range(1, 255)),
                          8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)),
                          12'($urandom), 12'(i), 13'($urandom)), 1, 0, 0);
      checkOutput("stream_level", 80'(level_o), 80'(3));
    end
    drain();

    // Pop while empty, then flush with valid and pop asserted.
    applyStimulus(0, 64'd0, 1, 0, 0);
    checkOutput("pop_empty_level", 80'(level_o), 80'(0));
    applyStimulus(1, tbl[4].word, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      applyStimulus(1, mk(1, 8'(16 + i), 8, 8, 12'(i), 12'(i), 13'h0), 0, 0, 0);
    applyStimulus(1, tbl[2].word, 1, 1, 0);
    checkOutput("flush_empty", 80'(iq_empty_o), 80'(1));
    checkOutput("flush_level", 80'(level_o), 80'(0));
    checkOutput("flush_keeps_err", 80'(err_illegal_o), 80'(1));
    applyStimulus(0, 64'd0, 0, 0, 0);
    checkOutput("flush_not_stored", 80'(level_o), 80'(0));

    // Asynchronous reset between edges while streaming.
    for (int i = 0; i < 4; i++)
      applyStimulus(1, mk(2, 8'(40 + i), 8, 8, 12'(i), 12'(i), 13'h0), 0, 0, 0);
    applyStimulus(1, tbl[5].word, 1, 0, 0);
    #2;
    rstN_i = 1'b0;
    #1;
    checkResetState("async_reset");
    resetModel();
    @(negedge clk_i);
    rstN_i = 1'b1;
    applyStimulus(0, 64'd0, 0, 0, 0);
    applyStimulus(1, tbl[8].word, 0, 0, 0);
    applyStimulus(0, 64'd0, 0, 0, 0);
    checkOutput("post_reset_V1", 80'(decoded_instruction_o.V_dim1), 80'(0));
    checkOutput("post_reset_U1", 80'(decoded_instruction_o.U_dim1), 80'(1));
    checkOutput("post_reset_I1", 80'(decoded_instruction_o.ITER_dim1), 80'(2));
    checkOutput("post_reset_level", 80'(level_o), 80'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
